// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes raw switch inputs and accepts a level change only
// after it has held stable for STABLE_CYCLES clocks, emitting one-cycle rise/fall pulses.
module switch_debouncer #(
   parameter int N             = 4,
   parameter int STABLE_CYCLES = 240000
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] s_raw,
   output logic [N-1:0] s_db,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall
);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   typedef enum logic {STABLE, PENDING} state_t;
   logic [N-1:0] sync1, sync2;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= s_raw;
         sync2 <= sync1;
      end
   end
   for (genvar i = 0; i < N; i++) begin : g_ch
      state_t st, st_nx;
      logic [CNT_W-1:0] cnt, cnt_nx;
      logic db_q, rise_q, fall_q, mis, acc;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            st     <= STABLE;
            cnt    <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            st     <= st_nx;
            cnt    <= cnt_nx;
            db_q   <= acc ? sync2[i] : db_q;
            rise_q <= acc & sync2[i];
            fall_q <= acc & ~sync2[i];
         end
      end
      // a bounce back to the accepted level forfeits all progress
      always_comb begin
         st_nx  = (mis && !acc) ? PENDING : STABLE;
         cnt_nx = (mis && !acc) ? cnt + 1'b1 : '0;
      end
      // in STABLE the counter is zero, so only a one-cycle threshold accepts at once
      always_comb begin
         mis = sync2[i] ^ db_q;
         acc = mis && ((st == STABLE) ? (STABLE_CYCLES == 1) : (cnt == LAST));
      end
      assign s_db[i] = db_q;
      assign rise[i] = rise_q;
      assign fall[i] = fall_q;
   end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and randomized checks of switch_debouncer against a
// sliding-window model of the raw input history.
module tb_switch_debouncer;
   localparam int N  = 4;
   localparam int SC = 4;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0] s_raw = '0, s_db, rise, fall;
   int n_cmp = 0, n_bad = 0;
   int n_rise [N], n_fall [N];
   always #5 clk = ~clk;
   switch_debouncer #(.N(N), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .reset_n(reset_n), .s_raw(s_raw), .s_db(s_db), .rise(rise), .fall(fall)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: the counter at an edge sees the raw value sampled two edges earlier;
   // a change is accepted when the last SC such values all oppose the current level
   logic [N-1:0] hist [0:SC];
   logic [N-1:0] m_db, m_rise, m_fall;
   always @(posedge clk or negedge reset_n) begin : model
      logic [N-1:0] all1, all0;
      if (!reset_n) begin
         for (int i = 0; i <= SC; i++) hist[i] = '0;
         m_db = '0; m_rise = '0; m_fall = '0;
      end else begin
         all1 = '1; all0 = '1;
         for (int i = 1; i <= SC; i++) begin
            all1 &= hist[i];
            all0 &= ~hist[i];
         end
         m_rise = all1 & ~m_db;
         m_fall = all0 & m_db;
         m_db   = m_db ^ (m_rise | m_fall);
         for (int i = SC; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = s_raw;
      end
   end
   always @(negedge clk) begin
      chk("s_db", 32'(s_db), 32'(m_db));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      if (reset_n)
         for (int i = 0; i < N; i++) begin
            n_rise[i] += int'(rise[i]);
            n_fall[i] += int'(fall[i]);
         end
   end
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic clr_cnt();
      for (int i = 0; i < N; i++) begin
         n_rise[i] = 0;
         n_fall[i] = 0;
      end
   endtask
   initial begin
      clr_cnt();
      for (int c = 0; c < 10; c++) begin
         step(1);
         s_raw = 4'($urandom);
         chk("rst_db", 32'(s_db), 0);
         chk("rst_pulse", 32'(rise | fall), 0);
      end
      s_raw = '0;
      step(1);
      reset_n = 1'b1;
      step(10);
      s_raw = 4'b0001;
      step(5);
      chk("clean_early", 32'(s_db), 0);
      step(1);
      chk("clean_db", 32'(s_db), 32'h1);
      chk("clean_rise", 32'(rise), 32'h1);
      chk("clean_fall", 32'(fall), 0);
      step(1);
      chk("clean_rise_off", 32'(rise), 0);
      s_raw = '0;
      step(10);
      s_raw = 4'b1011;
      step(5);
      chk("simul_early", 32'(rise), 0);
      step(1);
      chk("simul_rise", 32'(rise), 32'hb);
      chk("simul_db", 32'(s_db), 32'hb);
      step(1);
      chk("simul_rise_off", 32'(rise), 0);
      s_raw = 4'b1001;
      step(5);
      chk("fall_early", 32'(fall), 0);
      step(1);
      chk("fall_pulse", 32'(fall), 32'h2);
      chk("fall_db", 32'(s_db), 32'h9);
      step(1);
      chk("fall_off", 32'(fall), 0);
      s_raw = '0;
      step(10);
      clr_cnt();
      for (int k = 0; k < 4; k++) begin
         s_raw[2] = ~k[0];
         step(2);
      end
      s_raw[2] = 1'b1;
      step(12);
      chk("bounce_rise_n", n_rise[2], 1);
      chk("bounce_fall_n", n_fall[2], 0);
      s_raw[3] = 1'b1;
      step(3);
      s_raw[3] = 1'b0;
      step(12);
      chk("glitch_n", n_rise[3] + n_fall[3], 0);
      chk("glitch_db", 32'(s_db), 32'h4);
      s_raw = 4'b0001;
      step(4);
      reset_n = 1'b0;
      #1;
      chk("midrst_db", 32'(s_db), 0);
      chk("midrst_pulse", 32'(rise | fall), 0);
      step(2);
      s_raw = 4'b0101;
      reset_n = 1'b1;
      step(5);
      chk("midrst_early", 32'(rise), 0);
      step(1);
      chk("midrst_rise", 32'(rise), 32'h5);
      for (int c = 0; c < 3000; ) begin
         int d;
         d = $urandom_range(1, 8);
         s_raw = 4'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            reset_n = 1'b0;
            step($urandom_range(1, 3));
            reset_n = 1'b1;
         end
         step(d);
         c += d;
      end
      s_raw = '0;
      step(12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
